// File: rtl/instr_fetch_unit.sv
// MISC-V fetch stage: owns the PC, fetches 16-bit instructions over imem req/ack, feeds IF/ID.
// Optional build macro FETCH_PERF_EN adds saturating delivery / wait-cycle counters.
module instr_fetch_unit #(
   parameter logic [15:0] RESET_PC   = 16'h0000,
   parameter logic [15:0] PC_INC     = 16'd2,
   parameter int unsigned WAIT_LIMIT = 15
) (
   input  logic        CLK,
   input  logic        reset,
   input  logic        stall,
   input  logic        redirect,
   input  logic [15:0] redirect_pc,
   output logic        imem_req,
   output logic [15:0] imem_addr,
   input  logic        imem_ack,
   input  logic [15:0] imem_rdata,
   output logic [15:0] if_pc,
   output logic [15:0] if_ir,
   output logic        if_valid,
   output logic        if_write,
   output logic        fetch_err,
   output logic [15:0] perf_fetch,
   output logic [15:0] perf_wait
);

   localparam int unsigned W_PC   = 16;
   localparam int unsigned W_WAIT = 8;
   localparam logic [W_WAIT-1:0] WAIT_LIM = W_WAIT'(WAIT_LIMIT);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_REQ     = 2'd1,
      S_PRESENT = 2'd2,
      S_DISCARD = 2'd3
   } state_t;

   state_t            r_state;
   logic [W_PC-1:0]   r_pc;
   logic [W_PC-1:0]   r_old_addr;
   logic [W_PC-1:0]   r_if_pc;
   logic [W_PC-1:0]   r_if_ir;
   logic [W_WAIT-1:0] r_wait_cnt;
   logic              r_fetch_err;

   logic [W_PC-1:0]   w_redir_pc;
   logic              w_req;
   logic              w_waiting;
   logic [W_WAIT-1:0] w_wait_inc;

   assign w_redir_pc = redirect_pc & 16'hFFFE;
   assign w_req      = (r_state == S_REQ) || (r_state == S_DISCARD);
   assign w_waiting  = w_req && !imem_ack;
   assign w_wait_inc = (r_wait_cnt == {W_WAIT{1'b1}}) ? r_wait_cnt : r_wait_cnt + W_WAIT'(1);

   // Fetch sequencing; redirect outranks ack and stall in every state
   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_pc       <= RESET_PC;
         r_old_addr <= '0;
         r_if_pc    <= '0;
         r_if_ir    <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (redirect) r_pc <= w_redir_pc;
               r_state <= S_REQ;
            end
            S_REQ: begin
               if (redirect) begin
                  r_pc <= w_redir_pc;
                  if (!imem_ack) begin
                     // request already on the bus must complete before the new one
                     r_old_addr <= r_pc;
                     r_state    <= S_DISCARD;
                  end
               end else if (imem_ack) begin
                  r_if_ir <= imem_rdata;
                  r_if_pc <= r_pc;
                  r_state <= S_PRESENT;
               end
            end
            S_PRESENT: begin
               if (redirect) begin
                  r_pc    <= w_redir_pc;
                  r_state <= S_REQ;
               end else if (!stall) begin
                  r_pc    <= r_pc + PC_INC;
                  r_state <= S_REQ;
               end
            end
            S_DISCARD: begin
               if (redirect) r_pc <= w_redir_pc;
               if (imem_ack) r_state <= S_REQ;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Consecutive un-acked request cycles; error is sticky until reset
   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         r_wait_cnt  <= '0;
         r_fetch_err <= 1'b0;
      end else if (w_req) begin
         if (imem_ack) begin
            r_wait_cnt <= '0;
         end else begin
            r_wait_cnt <= w_wait_inc;
            if (w_wait_inc >= WAIT_LIM) r_fetch_err <= 1'b1;
         end
      end
   end

   assign imem_req  = w_req;
   assign imem_addr = (r_state == S_DISCARD) ? r_old_addr : r_pc;
   assign if_pc     = r_if_pc;
   assign if_ir     = r_if_ir;
   assign if_valid  = (r_state == S_PRESENT);
   assign if_write  = (r_state == S_PRESENT) && !stall && !redirect;
   assign fetch_err = r_fetch_err;

`ifdef FETCH_PERF_EN
   logic [15:0] r_perf_fetch;
   logic [15:0] r_perf_wait;

   // Saturating performance counters
   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         r_perf_fetch <= '0;
         r_perf_wait  <= '0;
      end else begin
         if (if_write && (r_perf_fetch != 16'hFFFF)) r_perf_fetch <= r_perf_fetch + 16'd1;
         if (w_waiting && (r_perf_wait != 16'hFFFF)) r_perf_wait <= r_perf_wait + 16'd1;
      end
   end

   assign perf_fetch = r_perf_fetch;
   assign perf_wait  = r_perf_wait;
`else
   assign perf_fetch = 16'h0000;
   assign perf_wait  = 16'h0000;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: memory model with programmable latency, scoreboard of delivered PCs.
module tb_instr_fetch_unit;

   logic        CLK;
   logic        reset;
   logic        stall;
   logic        redirect;
   logic [15:0] redirect_pc;
   logic        imem_req;
   logic [15:0] imem_addr;
   logic        imem_ack;
   logic [15:0] imem_rdata;
   logic [15:0] if_pc;
   logic [15:0] if_ir;
   logic        if_valid;
   logic        if_write;
   logic        fetch_err;
   logic [15:0] perf_fetch;
   logic [15:0] perf_wait;

`ifdef FETCH_PERF_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   int total = 0;
   int bad = 0;
   int n_deliv = 0;
   int m_fetch = 0;
   int m_wait = 0;
   int lat_fixed = 0;
   bit no_ack = 1'b0;
   logic [15:0] exp_q[$];

   instr_fetch_unit dut (
      .CLK(CLK), .reset(reset), .stall(stall), .redirect(redirect),
      .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata), .if_pc(if_pc), .if_ir(if_ir),
      .if_valid(if_valid), .if_write(if_write), .fetch_err(fetch_err),
      .perf_fetch(perf_fetch), .perf_wait(perf_wait)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Memory: each request acked after a chosen number of wait cycles, data = addr ^ A5A5
   initial begin
      bit busy;
      int left;
      logic [15:0] held;
      busy = 1'b0; left = 0; held = '0;
      imem_ack = 1'b0; imem_rdata = '0;
      forever begin
         @(posedge CLK); #1;
         if (reset || !imem_req) begin
            busy = 1'b0;
            imem_ack = 1'b0;
         end else begin
            if (!busy) begin
               busy = 1'b1;
               left = (lat_fixed < 0) ? int'($urandom_range(0, 3)) : lat_fixed;
               held = imem_addr;
            end else begin
               chk("addr_stable", 32'(imem_addr), 32'(held));
            end
            if (no_ack) begin
               imem_ack = 1'b0;
            end else if (left == 0) begin
               imem_ack = 1'b1;
               imem_rdata = imem_addr ^ 16'hA5A5;
               busy = 1'b0;
            end else begin
               imem_ack = 1'b0;
               left--;
            end
         end
      end
   end

   // Monitor: every IF/ID write must match the next PC of the reference program flow
   initial begin
      logic [15:0] e;
      forever begin
         @(negedge CLK);
         if (!reset) begin
            if (imem_req && !imem_ack) m_wait++;
            if (if_write) begin
               m_fetch++;
               n_deliv++;
               if (exp_q.size() == 0) begin
                  total++; bad++;
                  $display("FAIL sb_unexpected: got pc %0h want no delivery", if_pc);
               end else begin
                  e = exp_q.pop_front();
                  chk("sb_pc", 32'(if_pc), 32'(e));
                  chk("sb_ir", 32'(if_ir), 32'(e ^ 16'hA5A5));
                  exp_q.push_back(e + 16'd2);
               end
            end
         end
      end
   end

   task automatic do_reset();
      reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
      #1;
      chk("rst_req_async", 32'(imem_req), 32'd0);
      chk("rst_err_async", 32'(fetch_err), 32'd0);
      @(negedge CLK);
      chk("rst_if_pc", 32'(if_pc), 32'd0);
      chk("rst_if_ir", 32'(if_ir), 32'd0);
      chk("rst_valid", 32'(if_valid), 32'd0);
      chk("rst_write", 32'(if_write), 32'd0);
      chk("rst_perf_fetch", 32'(perf_fetch), 32'd0);
      chk("rst_perf_wait", 32'(perf_wait), 32'd0);
      exp_q.delete();
      exp_q.push_back(16'h0000);
      m_fetch = 0; m_wait = 0; n_deliv = 0;
      @(negedge CLK);
      reset = 1'b0;
   endtask

   task automatic do_redirect(input logic [15:0] tgt);
      redirect = 1'b1;
      redirect_pc = tgt;
      exp_q.delete();
      exp_q.push_back(tgt & 16'hFFFE);
   endtask

   initial begin
      int d0;
      bit done;
      #200000;
      $display("FAIL watchdog: got timeout want test end");
      $fatal(1, "watchdog");
   end

   initial begin
      int d0;
      bit done;
      // zero-wait streaming, then a 3-cycle stall at pc 0004
      lat_fixed = 0;
      do_reset();
      for (int c = 1; c <= 10; c++) begin
         @(posedge CLK); #1;
         stall = (c >= 6 && c <= 8);
         @(negedge CLK);
         case (c)
            1, 3, 5, 10: begin
               chk("t1_req", 32'(imem_req), 32'd1);
               chk("t1_addr", 32'(imem_addr), (c == 10) ? 32'h6 : 32'(c - 1));
               chk("t1_write_off", 32'(if_write), 32'd0);
            end
            2, 4, 9: begin
               chk("t1_write", 32'(if_write), 32'd1);
               chk("t1_req_off", 32'(imem_req), 32'd0);
            end
            default: begin
               chk("t2_write", 32'(if_write), 32'd0);
               chk("t2_req", 32'(imem_req), 32'd0);
               chk("t2_valid", 32'(if_valid), 32'd1);
               chk("t2_ir_hold", 32'(if_ir), 32'hA5A1);
               chk("t2_pc_hold", 32'(if_pc), 32'h4);
            end
         endcase
      end

      // redirect in the first wait cycle of a 3-latency fetch
      lat_fixed = 3;
      do_reset();
      for (int c = 1; c <= 9; c++) begin
         @(posedge CLK); #1;
         if (c == 1) do_redirect(16'h0101);
         else redirect = 1'b0;
         @(negedge CLK);
         if (c >= 2 && c <= 4) begin
            chk("t3_req_held", 32'(imem_req), 32'd1);
            chk("t3_addr_held", 32'(imem_addr), 32'h0);
         end
         if (c == 5) chk("t3_new_addr", 32'(imem_addr), 32'h0100);
         if (c == 9) begin
            chk("t3_write", 32'(if_write), 32'd1);
            chk("t3_if_pc", 32'(if_pc), 32'h0100);
         end
      end

      // PC wrap after redirect to FFFE
      lat_fixed = 0;
      @(posedge CLK); #1;
      do_redirect(16'hFFFE);
      @(posedge CLK); #1;
      redirect = 1'b0;
      d0 = n_deliv;
      repeat (10) @(posedge CLK);
      @(negedge CLK); #1;
      chk("t4_wrap_deliv", 32'(n_deliv - d0 >= 2), 32'd1);

      // random stall / redirect / latency
      lat_fixed = -1;
      do_reset();
      for (int c = 0; c < 600; c++) begin
         @(posedge CLK); #1;
         stall = ($urandom_range(0, 99) < 30);
         if ($urandom_range(0, 99) < 6) do_redirect(16'($urandom));
         else redirect = 1'b0;
      end
      @(posedge CLK); #1;
      stall = 1'b0; redirect = 1'b0;
      @(posedge CLK); #3;
      chk("rnd_perf_fetch", 32'(perf_fetch), PERF ? 32'(m_fetch) : 32'd0);
      chk("rnd_perf_wait", 32'(perf_wait), PERF ? 32'(m_wait) : 32'd0);
      chk("rnd_progress", 32'(n_deliv > 50), 32'd1);
      chk("rnd_no_err", 32'(fetch_err), 32'd0);

      // four deliveries, one wait cycle each
      lat_fixed = 1;
      do_reset();
      done = 1'b0;
      for (int c = 0; c < 100 && !done; c++) begin
         @(negedge CLK); #1;
         if (n_deliv == 4) done = 1'b1;
      end
      chk("t6_reached", 32'(done), 32'd1);
      @(posedge CLK); #3;
      chk("t6_perf_fetch", 32'(perf_fetch), PERF ? 32'd4 : 32'd0);
      chk("t6_perf_wait", 32'(perf_wait), PERF ? 32'd4 : 32'd0);

      // wait timeout, then asynchronous reset mid-wait
      no_ack = 1'b1;
      do_reset();
      for (int c = 1; c <= 20; c++) begin
         @(negedge CLK);
         chk("t5_req", 32'(imem_req), 32'd1);
         chk("t5_err", 32'(fetch_err), 32'(c >= 16));
      end
      @(posedge CLK); #2;
      reset = 1'b1;
      #1;
      chk("t5_async_req", 32'(imem_req), 32'd0);
      chk("t5_async_err", 32'(fetch_err), 32'd0);
      no_ack = 1'b0;
      do_reset();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
